// File: rtl/hq_energy_selector_if.sv
// Hq sample stream: one signed complex element per valid beat,
// done marks the eighth (last) element of a matrix.
interface hq_energy_selector_if #(
  parameter int N = 16
);
  logic                Hq_in_valid;
  logic signed [N-1:0] Hq_in_r;
  logic signed [N-1:0] Hq_in_i;
  logic                hq_one_matrix_done;

  modport master (
    output Hq_in_valid,
    output Hq_in_r,
    output Hq_in_i,
    output hq_one_matrix_done
  );

  modport slave (
    input Hq_in_valid,
    input Hq_in_r,
    input Hq_in_i,
    input hq_one_matrix_done
  );
endinterface

// File: rtl/hq_energy_selector.sv
// Picks the highest-energy Hq matrix out of 16; define
// HQ_ENERGY_STREAM_EN to expose the per-matrix energy stream.
module hq_energy_selector #(
  parameter int N         = 16,
  parameter int ACC_WIDTH = 36
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  hq_energy_selector_if.slave  hq,
  output logic                 busy,
  output logic                 energy_valid,
  output logic [ACC_WIDTH-1:0] energy_out,
  output logic [3:0]           energy_q,
  output logic                 sel_valid,
  output logic [3:0]           sel_q_index,
  output logic [ACC_WIDTH-1:0] sel_energy,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0] elem;
  logic [3:0] in_q;
  logic       tail;
  logic       fresh;

  logic           s1_valid;
  logic           s1_done;
  logic           s1_first;
  logic [2*N-1:0] s1_e;

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] best;
  logic [3:0]           best_q;
  logic [3:0]           q;

  logic go;
  logic accept;
  logic close;
  logic last;

  logic signed [2*N-1:0] rr;
  logic signed [2*N-1:0] ii;
  logic [2*N-1:0]        e0;
  logic [ACC_WIDTH-1:0]  e1;
  logic [ACC_WIDTH-1:0]  m_e;
  logic                  upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ACCUM;
      ACCUM:   if (last)  state_nx = DONE;
      DONE:    if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // tail blocks samples that arrive after matrix 15 closed upstream
  always_comb begin
    go     = (state == IDLE) && start;
    busy   = (state == ACCUM);
    accept = busy && hq.Hq_in_valid && !tail;
    close  = busy && s1_valid && s1_done;
    last   = close && (q == 4'd15);
  end

  always_comb begin
    rr  = hq.Hq_in_r * hq.Hq_in_r;
    ii  = hq.Hq_in_i * hq.Hq_in_i;
    e0  = $unsigned(rr) + $unsigned(ii);
    e1  = {{(ACC_WIDTH-2*N){1'b0}}, s1_e};
    m_e = s1_first ? e1 : acc + e1;
    upd = (q == 4'd0) || (m_e > best);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem      <= '0;
      in_q      <= '0;
      tail      <= 1'b0;
      fresh     <= 1'b1;
      proto_err <= 1'b0;
    end else if (go) begin
      elem      <= '0;
      in_q      <= '0;
      tail      <= 1'b0;
      fresh     <= 1'b1;
      proto_err <= 1'b0;
    end else if (accept) begin
      fresh <= hq.hq_one_matrix_done;
      elem  <= hq.hq_one_matrix_done ? 3'd0 : elem + 3'd1;
      if (hq.hq_one_matrix_done ^ (elem == 3'd7))
        proto_err <= 1'b1;
      if (hq.hq_one_matrix_done) begin
        in_q <= in_q + 4'd1;
        if (in_q == 4'd15) tail <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_done  <= 1'b0;
      s1_first <= 1'b0;
      s1_e     <= '0;
    end else begin
      s1_valid <= accept;
      s1_done  <= accept && hq.hq_one_matrix_done;
      if (accept) begin
        s1_first <= fresh;
        s1_e     <= e0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      best        <= '0;
      best_q      <= '0;
      q           <= '0;
      sel_valid   <= 1'b0;
      sel_q_index <= '0;
      sel_energy  <= '0;
    end else if (go) begin
      acc         <= '0;
      best        <= '0;
      best_q      <= '0;
      q           <= '0;
      sel_valid   <= 1'b0;
      sel_q_index <= '0;
      sel_energy  <= '0;
    end else begin
      sel_valid <= last;
      if (busy && s1_valid) acc <= m_e;
      if (close && !last) q <= q + 4'd1;
      if (close && upd) begin
        best   <= m_e;
        best_q <= q;
      end
      if (last) begin
        sel_q_index <= upd ? q : best_q;
        sel_energy  <= upd ? m_e : best;
      end
    end
  end

`ifdef HQ_ENERGY_STREAM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energy_valid <= 1'b0;
      energy_out   <= '0;
      energy_q     <= '0;
    end else begin
      energy_valid <= close;
      if (close) begin
        energy_out <= m_e;
        energy_q   <= q;
      end
    end
  end
`else
  assign energy_valid = 1'b0;
  assign energy_out   = '0;
  assign energy_q     = '0;
`endif

endmodule

// File: tb/tb_hq_energy_selector.sv
// Self-checking bench: table of 16-matrix runs, scoreboard of
// expected selections (and energies when the stream is enabled).
module tb_hq_energy_selector;
  localparam int N  = 16;
  localparam int AW = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          energy_valid;
  logic [AW-1:0] energy_out;
  logic [3:0]    energy_q;
  logic          sel_valid;
  logic [3:0]    sel_q_index;
  logic [AW-1:0] sel_energy;
  logic          proto_err;

  always #5 clk = ~clk;

  hq_energy_selector_if #(.N(N)) hq ();

  hq_energy_selector #(.N(N), .ACC_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .hq           (hq),
    .busy         (busy),
    .energy_valid (energy_valid),
    .energy_out   (energy_out),
    .energy_q     (energy_q),
    .sel_valid    (sel_valid),
    .sel_q_index  (sel_q_index),
    .sel_energy   (sel_energy),
    .proto_err    (proto_err)
  );

  typedef struct {
    int      def_r, def_i;
    int      sp_q, sp_r, sp_i;
    int      short_q;
    bit      gap, drop;
    int      exp_q;
    longint  exp_e;
    bit      exp_err;
  } vec_t;

  typedef struct {
    int     q;
    longint e;
    bit     err;
  } sel_t;

  typedef struct {
    int     q;
    longint e;
    int     due;
  } en_t;

  vec_t vecs[7];
  sel_t sel_q[$];
  en_t  en_q[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int sel_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int dr, int di, int sq, int sr, int si,
                              int shq, bit g, bit d, int eq, longint ee,
                              bit er);
    vec_t v;
    v.def_r = dr; v.def_i = di;
    v.sp_q = sq; v.sp_r = sr; v.sp_i = si;
    v.short_q = shq; v.gap = g; v.drop = d;
    v.exp_q = eq; v.exp_e = ee; v.exp_err = er;
    return v;
  endfunction

  function automatic longint e_of(int r, int i);
    return longint'(r) * longint'(r) + longint'(i) * longint'(i);
  endfunction

  always @(negedge clk) begin
    if (rst_n && sel_valid) begin
      sel_cnt++;
      chk("busy low at sel_valid", longint'(busy), 0);
      if (sel_q.size() == 0) begin
        chk("unexpected sel_valid", 1, 0);
      end else begin
        sel_t s;
        s = sel_q.pop_front();
        chk("sel_q_index", longint'(sel_q_index), longint'(s.q));
        chk("sel_energy", longint'(sel_energy), s.e);
        chk("proto_err", longint'(proto_err), longint'(s.err));
      end
    end
`ifdef HQ_ENERGY_STREAM_EN
    if (rst_n && energy_valid) begin
      if (en_q.size() == 0) begin
        chk("unexpected energy_valid", 1, 0);
      end else begin
        en_t x;
        x = en_q.pop_front();
        chk("energy_q", longint'(energy_q), longint'(x.q));
        chk("energy_out", longint'(energy_out), x.e);
        chk("energy latency", longint'(cyc), longint'(x.due));
      end
    end
`endif
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      hq.Hq_in_valid = 1'b0;
      hq.Hq_in_r = N'($urandom);
      hq.Hq_in_i = N'($urandom);
      hq.hq_one_matrix_done = 1'($urandom);
    end
  endtask

  task automatic drive(input int r, input int i, input bit d);
    @(posedge clk); #1;
    hq.Hq_in_valid = 1'b1;
    hq.Hq_in_r = N'(r);
    hq.Hq_in_i = N'(i);
    hq.hq_one_matrix_done = d;
  endtask

  // drives matrices 0..nq-1; last matrix stops after part elements if part>0
  task automatic feed(input vec_t v, input int nq, input int part);
    for (int q = 0; q < nq; q++) begin
      int n_el;
      longint me;
      n_el = (q == v.short_q) ? 6 : 8;
      if (part > 0 && q == nq - 1) n_el = part;
      me = 0;
      for (int k = 0; k < n_el; k++) begin
        int r, i;
        bit d;
        r = (q == v.sp_q) ? v.sp_r : v.def_r;
        i = (q == v.sp_q) ? v.sp_i : v.def_i;
        d = (k == n_el - 1) && !(part > 0 && q == nq - 1);
        me += e_of(r, i);
        drive(r, i, d);
        if (d) en_q.push_back('{q, me, cyc + 2});
        if (v.drop && k == 0 && q == 2) start = 1'b0;
        if (v.drop && k == 0 && q == 4) start = 1'b1;
        if (v.gap && $urandom_range(0, 2) == 0)
          idle($urandom_range(1, 2));
      end
      if (q == 0) chk("busy during run", longint'(busy), 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base;
    base = sel_cnt;
    sel_q.push_back('{v.exp_q, v.exp_e, v.exp_err});
    @(posedge clk); #1;
    start = 1'b1;
    feed(v, 16, 0);
    idle(1);
    for (int t = 0; t < 20 && sel_cnt == base; t++) begin
      @(posedge clk); #6;
    end
    if (sel_cnt == base) begin
      chk({tag, " sel_valid timeout"}, 0, 1);
      void'(sel_q.pop_back());
    end
    @(posedge clk); #6;
    chk({tag, " sel_valid one cycle"}, longint'(sel_valid), 0);
    chk({tag, " busy after run"}, longint'(busy), 0);
    chk({tag, " sel_q_index held"}, longint'(sel_q_index), longint'(v.exp_q));
`ifndef HQ_ENERGY_STREAM_EN
    chk({tag, " energy tie-off"},
        longint'({energy_valid, energy_q}) + longint'(energy_out), 0);
`endif
    start = 1'b0;
    idle(2);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = mk(1, 1, 9, 1, -1, -1, 0, 0, 0, 16, 0);
    vecs[1] = mk(1, 1, 9, 2, 0, -1, 0, 0, 9, 32, 0);
    vecs[2] = mk(10, 10, 5, 100, -100, -1, 0, 0, 5, 160000, 0);
    vecs[3] = mk(-32768, -32768, -1, 0, 0, -1, 0, 0, 0, 64'd17179869184, 0);
    vecs[4] = mk(3, 4, 15, 4, 4, -1, 0, 0, 15, 256, 0);
    vecs[5] = mk(1, 1, -1, 0, 0, 3, 0, 0, 0, 16, 1);
    vecs[6] = mk(2, 3, 7, -7, 1, -1, 1, 1, 7, 400, 0);

    hq.Hq_in_valid = 1'b0;
    hq.Hq_in_r = '0;
    hq.Hq_in_i = '0;
    hq.hq_one_matrix_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", longint'(busy), 0);
    chk("reset sel_valid", longint'(sel_valid), 0);
    chk("reset sel_q_index", longint'(sel_q_index), 0);
    chk("reset sel_energy", longint'(sel_energy), 0);
    chk("reset proto_err", longint'(proto_err), 0);
    chk("reset energy_valid", longint'(energy_valid), 0);
    rst_n = 1'b1;
    idle(2);

    for (int n = 0; n < 7; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    rv = mk(1, 1, -1, 0, 0, 2, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    start = 1'b1;
    feed(rv, 8, 3);
    chk("busy before reset", longint'(busy), 1);
    chk("proto_err before reset", longint'(proto_err), 1);
    #3;
    rst_n = 1'b0;
    start = 1'b0;
    hq.Hq_in_valid = 1'b0;
    #1;
    chk("async rst busy", longint'(busy), 0);
    chk("async rst proto_err", longint'(proto_err), 0);
    chk("async rst sel_valid", longint'(sel_valid), 0);
    chk("async rst sel_energy", longint'(sel_energy), 0);
    chk("async rst energy_out", longint'(energy_out), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    run_vec(vecs[2], "post-reset");

    idle(4);
    chk("sel scoreboard drained", longint'(sel_q.size()), 0);
`ifdef HQ_ENERGY_STREAM_EN
    chk("energy scoreboard drained", longint'(en_q.size()), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
